// File: rtl/fx_eq_pkg.sv
// Shared types and sizing helpers for the N-band fixed-point equaliser.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fx_eq_pkg;

    // Sequencer states: wait for a strobe, walk bands/channels, publish.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_DONE = 2'd2
    } eq_state_t;

    // Gain code that leaves a band at unity (0 dB).
    function automatic int unity_gain(input int param_w);
        return 1 << (param_w - 1);
    endfunction

    // Accumulator width: room for the band value times an unsigned gain,
    // summed over every band, plus guard bits.
    function automatic int acc_width(input int data_w, input int param_w, input int num_bands);
        return data_w + param_w + $clog2(num_bands) + 3;
    endfunction

    // One-pole shift for crossover k: the lowest crossover is the slowest.
    // The top band has no crossover state, so it gets a don't-care 0.
    function automatic int band_shift(input int shift_base, input int num_bands, input int k);
        if (k >= num_bands - 1) begin
            return 0;
        end
        return shift_base + 2 * (num_bands - 2 - k);
    endfunction

endpackage

// File: rtl/fx_eq_band_mac.sv
// One band step: one-pole crossover update, band split, gain multiply-accumulate.
// Latency: purely combinational; the parent registers the state and accumulator.
// Backpressure: none, it evaluates every cycle and the parent decides what to keep.
module fx_eq_band_mac
    import fx_eq_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 7,
    parameter int ACC_W   = 28
) (
    input  logic signed [DATA_W-1:0]  x,
    input  logic signed [DATA_W+1:0]  s_cur,
    input  logic signed [DATA_W+1:0]  s_lo,
    input  logic        [4:0]         shift,
    input  logic                      is_last,
    input  logic        [PARAM_W-1:0] gain,
    input  logic signed [ACC_W-1:0]   acc_in,
    output logic signed [DATA_W+1:0]  s_next,
    output logic signed [ACC_W-1:0]   acc_next
);

    localparam int SW = DATA_W + 2;
    localparam int DW = DATA_W + 3;
    localparam int PW = DW + PARAM_W + 1;

    logic signed [DW-1:0] x_ext;
    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] step;
    logic signed [DW-1:0] s_hi;
    logic signed [DW-1:0] band;
    logic signed [PW-1:0] prod;

    // Crossover update, then the band is the difference of adjacent lowpass
    // outputs (the top band uses the raw input), so the bands telescope to x.
    always_comb begin
        x_ext    = DW'(x);
        diff     = x_ext - DW'(s_cur);
        step     = diff >>> shift;
        s_next   = SW'(DW'(s_cur) + step);
        s_hi     = is_last ? x_ext : DW'(s_next);
        band     = s_hi - DW'(s_lo);
        prod     = PW'(band) * PW'($signed({1'b0, gain}));
        acc_next = acc_in + ACC_W'(prod);
    end

endmodule

// File: rtl/fx_eq_nband.sv
// N-band graphic equaliser; one shared band MAC time-sliced over bands and channels.
// Latency: strobe at T -> out_valid at T+NUM_CH*NUM_BANDS+1, idle again at T+NUM_CH*NUM_BANDS+2.
// Backpressure: none; a strobe while busy is dropped and latches the sticky overrun flag.
module fx_eq_nband
    import fx_eq_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int PARAM_W    = 7,
    parameter int NUM_CH     = 2,
    parameter int NUM_BANDS  = 4,
    parameter int SHIFT_BASE = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CH-1:0][DATA_W-1:0]       audio_in,
    input  logic                                sample_en,
    input  logic [NUM_BANDS-1:0][PARAM_W-1:0]   band_gain,
    input  logic                                bypass,
    output logic [NUM_CH-1:0][DATA_W-1:0]       audio_out,
    output logic                                out_valid,
    output logic                                busy,
    output logic                                overrun
);

    localparam int ACC_W = acc_width(DATA_W, PARAM_W, NUM_BANDS);
    localparam int SW    = DATA_W + 2;
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW    = $clog2(NUM_BANDS);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    eq_state_t state_q;
    eq_state_t state_d;

    logic [CW-1:0] ch_cnt;
    logic [BW-1:0] band_cnt;

    // Crossover lowpass states, one set per channel.
    logic signed [SW-1:0] s_q [NUM_CH][NUM_BANDS-1];

    // Shadow copy of the sample and controls, frozen for the whole pass.
    logic [NUM_CH-1:0][DATA_W-1:0]     x_sh;
    logic [NUM_BANDS-1:0][PARAM_W-1:0] gain_sh;
    logic                              bypass_sh;

    logic signed [ACC_W-1:0]       acc_q;
    logic [NUM_CH-1:0][DATA_W-1:0] res_q;

    logic                     last_band;
    logic                     last_ch;
    logic signed [DATA_W-1:0] x_cur;
    logic signed [SW-1:0]     s_cur;
    logic signed [SW-1:0]     s_lo;
    logic [PARAM_W-1:0]       gain_cur;
    logic [4:0]               shift_cur;
    logic signed [SW-1:0]     s_next;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc_sh;
    logic [DATA_W-1:0]        ch_result;

    assign last_band = (band_cnt == BW'(NUM_BANDS - 1));
    assign last_ch   = (ch_cnt == CW'(NUM_CH - 1));
    assign busy      = (state_q != ST_IDLE);

    // Operand select for the current (channel, band) slot.
    always_comb begin
        x_cur     = $signed(x_sh[ch_cnt]);
        s_cur     = '0;
        s_lo      = '0;
        gain_cur  = '0;
        shift_cur = '0;
        for (int k = 0; k < NUM_BANDS - 1; k++) begin
            if (band_cnt == BW'(k)) begin
                s_cur     = s_q[ch_cnt][k];
                shift_cur = 5'(band_shift(SHIFT_BASE, NUM_BANDS, k));
            end
            if (band_cnt == BW'(k + 1)) begin
                s_lo = s_q[ch_cnt][k];
            end
        end
        for (int k = 0; k < NUM_BANDS; k++) begin
            if (band_cnt == BW'(k)) begin
                gain_cur = gain_sh[k];
            end
        end
    end

    fx_eq_band_mac #(
        .DATA_W  (DATA_W),
        .PARAM_W (PARAM_W),
        .ACC_W   (ACC_W)
    ) u_mac (
        .x        (x_cur),
        .s_cur    (s_cur),
        .s_lo     (s_lo),
        .shift    (shift_cur),
        .is_last  (last_band),
        .gain     (gain_cur),
        .acc_in   (acc_q),
        .s_next   (s_next),
        .acc_next (acc_next)
    );

    // Remove the unity-gain scale and clamp to the sample range.
    always_comb begin
        acc_sh = acc_next >>> (PARAM_W - 1);
        if (acc_sh > SAT_MAX) begin
            ch_result = SAT_MAX[DATA_W-1:0];
        end else if (acc_sh < SAT_MIN) begin
            ch_result = SAT_MIN[DATA_W-1:0];
        end else begin
            ch_result = acc_sh[DATA_W-1:0];
        end
        if (bypass_sh) begin
            ch_result = x_sh[ch_cnt];
        end
    end

    // Next-state logic for the band/channel sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sample_en) state_d = ST_PROC;
            ST_PROC: if (last_band && last_ch) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, capture, per-slot datapath registers and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ch_cnt    <= '0;
            band_cnt  <= '0;
            x_sh      <= '0;
            gain_sh   <= '0;
            bypass_sh <= 1'b0;
            acc_q     <= '0;
            res_q     <= '0;
            audio_out <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < NUM_BANDS - 1; k++) begin
                    s_q[c][k] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            out_valid <= 1'b0;
            if (sample_en && (state_q != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sample_en) begin
                        x_sh      <= audio_in;
                        gain_sh   <= band_gain;
                        bypass_sh <= bypass;
                        ch_cnt    <= '0;
                        band_cnt  <= '0;
                        acc_q     <= '0;
                    end
                end
                ST_PROC: begin
                    if (!last_band) begin
                        for (int k = 0; k < NUM_BANDS - 1; k++) begin
                            if (band_cnt == BW'(k)) begin
                                s_q[ch_cnt][k] <= s_next;
                            end
                        end
                        acc_q    <= acc_next;
                        band_cnt <= band_cnt + 1'b1;
                    end else begin
                        res_q[ch_cnt] <= ch_result;
                        acc_q         <= '0;
                        band_cnt      <= '0;
                        ch_cnt        <= last_ch ? '0 : ch_cnt + 1'b1;
                        if (last_ch) begin
                            // Publish every channel together; the last one
                            // comes straight from this cycle's MAC.
                            for (int c = 0; c < NUM_CH; c++) begin
                                audio_out[c] <= (CW'(c) == ch_cnt) ? ch_result : res_q[c];
                            end
                            out_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fx_eq_nband.sv
// Directed self-checking bench for fx_eq_nband at default parameters.
// Latency: expects out_valid exactly 9 cycles after each accepted strobe.
// Backpressure: exercises dropped strobes while busy and the sticky overrun flag.
module tb_fx_eq_nband;

    logic                 clk;
    logic                 reset;
    logic [1:0][15:0]     audio_in;
    logic                 sample_en;
    logic [3:0][6:0]      band_gain;
    logic                 bypass;
    logic [1:0][15:0]     audio_out;
    logic                 out_valid;
    logic                 busy;
    logic                 overrun;

    int n_cmp;
    int n_bad;

    fx_eq_nband dut (
        .clk       (clk),
        .reset     (reset),
        .audio_in  (audio_in),
        .sample_en (sample_en),
        .band_gain (band_gain),
        .bypass    (bypass),
        .audio_out (audio_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_gains(input int g0, input int g1, input int g2, input int g3);
        band_gain[0] = 7'(g0);
        band_gain[1] = 7'(g1);
        band_gain[2] = 7'(g2);
        band_gain[3] = 7'(g3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Strobe one sample, optionally swap gains mid-pass, wait for out_valid.
    // lat is the cycle offset of out_valid from the strobe, -1 on timeout.
    task automatic do_sample(input logic signed [15:0] a0, input logic signed [15:0] a1,
                             input logic [3:0][6:0] g_after, output int lat);
        @(negedge clk);
        audio_in[0] = a0;
        audio_in[1] = a1;
        sample_en   = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        band_gain = g_after;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (out_valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    int lat;
    int pulses;
    int first_pulse;

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        sample_en = 1'b0;
        bypass    = 1'b0;
        audio_in  = '0;
        set_gains(64, 64, 64, 64);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out0", $signed(audio_out[0]), 0);
        chk("rst_out1", $signed(audio_out[1]), 0);
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovr", 32'(overrun), 0);
        reset = 1'b0;

        // Unity gains: bands sum back to the input, sample after sample
        for (int i = 0; i < 200; i++) begin
            do_sample(16'sd1000, 16'sd1000, band_gain, lat);
            if (i == 0) begin
                chk("dc_lat", lat, 9);
                chk("dc_busy_done", 32'(busy), 1);
            end
            chk("dc_out0", $signed(audio_out[0]), 1000);
            chk("dc_out1", $signed(audio_out[1]), 1000);
        end
        @(negedge clk);
        chk("dc_vld_drop", 32'(out_valid), 0);
        chk("dc_idle", 32'(busy), 0);

        // Zero gains; raising gains mid-pass must not touch the in-flight sample
        set_gains(0, 0, 0, 0);
        do_sample(16'sd5000, -16'sd7000, {7'd127, 7'd127, 7'd127, 7'd127}, lat);
        chk("zero_lat", lat, 9);
        chk("zero_out0", $signed(audio_out[0]), 0);
        chk("zero_out1", $signed(audio_out[1]), 0);

        // Max gain: 127*x/64 is outside the sample range, clamp both ways
        set_gains(127, 127, 127, 127);
        do_sample(16'sd30000, 16'sd30000, band_gain, lat);
        chk("satp_lat", lat, 9);
        chk("satp_out0", $signed(audio_out[0]), 32767);
        chk("satp_out1", $signed(audio_out[1]), 32767);
        do_sample(-16'sd30000, -16'sd30000, band_gain, lat);
        chk("satn_out0", $signed(audio_out[0]), -32768);
        chk("satn_out1", $signed(audio_out[1]), -32768);
        do_sample(16'sd30000, -16'sd30000, band_gain, lat);
        chk("satm_out0", $signed(audio_out[0]), 32767);
        chk("satm_out1", $signed(audio_out[1]), -32768);

        // Second strobe 4 cycles into a pass is dropped and flagged
        set_gains(64, 64, 64, 64);
        @(negedge clk);
        audio_in[0] = 16'sd500;
        audio_in[1] = -16'sd500;
        sample_en   = 1'b1;
        pulses      = 0;
        first_pulse = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (first_pulse < 0) first_pulse = n;
            end
            sample_en = (n == 4);
        end
        chk("ovr_pulses", pulses, 1);
        chk("ovr_first", first_pulse, 9);
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_out0", $signed(audio_out[0]), 500);
        do_reset();
        chk("ovr_clear", 32'(overrun), 0);

        // Build some filter history, then abort a pass with reset at T+3
        do_sample(16'sd12800, 16'sd12800, band_gain, lat);
        chk("pre_out0", $signed(audio_out[0]), 12800);
        @(negedge clk);
        audio_in[0] = 16'sd9999;
        sample_en   = 1'b1;
        pulses      = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            sample_en = 1'b0;
            reset     = (n == 3);
            if (out_valid) pulses++;
        end
        chk("abort_pulses", pulses, 0);
        chk("abort_out0", $signed(audio_out[0]), 0);
        chk("abort_out1", $signed(audio_out[1]), 0);

        // Lowest band only, starting from cleared state: s0 = x>>>7 per step
        set_gains(64, 0, 0, 0);
        do_sample(16'sd12800, -16'sd12800, band_gain, lat);
        chk("b0_lat", lat, 9);
        chk("b0_s1_out0", $signed(audio_out[0]), 100);
        chk("b0_s1_out1", $signed(audio_out[1]), -100);
        do_sample(16'sd12800, -16'sd12800, band_gain, lat);
        chk("b0_s2_out0", $signed(audio_out[0]), 199);
        chk("b0_s2_out1", $signed(audio_out[1]), -200);

        // Top band only from cleared state: x - s2, s2 uses shift 3
        do_reset();
        set_gains(0, 0, 0, 64);
        do_sample(16'sd12800, -16'sd6400, band_gain, lat);
        chk("b3_s1_out0", $signed(audio_out[0]), 11200);
        chk("b3_s1_out1", $signed(audio_out[1]), -5600);
        do_sample(16'sd12800, -16'sd6400, band_gain, lat);
        chk("b3_s2_out0", $signed(audio_out[0]), 9800);
        chk("b3_s2_out1", $signed(audio_out[1]), -4900);

        // Bypass passes the captured input regardless of gains, then holds
        set_gains(0, 0, 0, 0);
        bypass = 1'b1;
        do_sample(16'sd1234, -16'sd1234, band_gain, lat);
        bypass = 1'b0;
        chk("byp_lat", lat, 9);
        chk("byp_out0", $signed(audio_out[0]), 1234);
        chk("byp_out1", $signed(audio_out[1]), -1234);
        repeat (5) @(negedge clk);
        chk("hold_out0", $signed(audio_out[0]), 1234);
        chk("hold_out1", $signed(audio_out[1]), -1234);
        chk("hold_vld", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
